// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with step enable and seed register.
// Rejects an all-zero seed and pulses wrap when the state returns to the seed.
//
// Parameters:
//   WIDTH      state width, 3..32
//   TAPS       tap mask, bit i taps state[i] (Galois needs bit0 = 1)
//   MODE       0 = Fibonacci, 1 = Galois
//   RESET_SEED state and seed after reset, nonzero
//
// Ports:
//   clock    rising-edge clock
//   reset    synchronous active-high reset
//   load     capture seed this cycle (wins over enable)
//   seed     seed value, WIDTH bits
//   enable   advance one step
//   Y        current state, registered
//   wrap     one-cycle pulse when an advance lands back on the seed
//   seed_err one-cycle pulse when a zero seed is loaded
//   period   last measured period, only when LFSR_PERIOD_CNT_EN is defined
//
// Optional feature macro: LFSR_PERIOD_CNT_EN (32-bit saturating step counter
// and the period output).
module lfsr_gen #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
  parameter int unsigned      MODE       = 0,
  parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  output logic [WIDTH-1:0] Y,
  output logic             wrap,
  output logic             seed_err
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [31:0]      period
`endif
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_nxt;
  logic             seed_zero;

  // One-step successor of the current state.
  generate
    if (MODE == 0) begin : g_fib
      assign step_nxt = {y_q[WIDTH-2:0], ^(y_q & TAPS)};
    end else begin : g_gal
      assign step_nxt = {y_q[WIDTH-2:0], 1'b0}
                      ^ (y_q[WIDTH-1] ? TAPS : '0);
    end
  endgenerate

  assign seed_zero = (seed == '0);

  // A zero seed would lock the register, so it is replaced by
  // RESET_SEED; this keeps the all-zero state unreachable.
  always_comb begin
    y_d    = y_q;
    seed_d = seed_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (seed_zero) begin
        y_d    = RESET_SEED;
        seed_d = RESET_SEED;
        err_d  = 1'b1;
      end else begin
        y_d    = seed;
        seed_d = seed;
      end
    end else if (enable) begin
      y_d    = step_nxt;
      wrap_d = (step_nxt == seed_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      y_q    <= RESET_SEED;
      seed_q <= RESET_SEED;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      y_q    <= y_d;
      seed_q <= seed_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Y        = y_q;
  assign wrap     = wrap_q;
  assign seed_err = err_q;

`ifdef LFSR_PERIOD_CNT_EN
  localparam logic [31:0] CNT_MAX = '1;

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] per_q, per_d;
  logic [31:0] cnt_inc;

  // Saturating increment; also used for the period so a saturated
  // count never rolls over to a tiny value.
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 32'd1;

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable) begin
      if (wrap_d) begin
        per_d = cnt_inc;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

  assign period = per_q;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench for lfsr_gen, Fibonacci (B8) and Galois (1D)
// instances driven in lockstep from shared inputs.
module tb_lfsr_gen;

  localparam logic [7:0] FT = 8'hB8;
  localparam logic [7:0] GT = 8'h1D;
  localparam logic [7:0] RS = 8'h01;
  localparam logic [31:0] CMAX = 32'hFFFF_FFFF;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       enable = 1'b0;

  logic [7:0] f_y, g_y;
  logic       f_w, f_e, g_w, g_e;
  logic [31:0] f_p;

  always #5 clock = ~clock;

  lfsr_gen #(.WIDTH(8), .TAPS(FT), .MODE(0), .RESET_SEED(RS)) u_fib (
    .clock(clock), .reset(reset), .load(load), .seed(seed),
    .enable(enable), .Y(f_y), .wrap(f_w), .seed_err(f_e)
`ifdef LFSR_PERIOD_CNT_EN
    , .period(f_p)
`endif
  );

`ifdef LFSR_PERIOD_CNT_EN
  logic [31:0] g_p;
`else
  assign f_p = 32'd0;
`endif

  lfsr_gen #(.WIDTH(8), .TAPS(GT), .MODE(1), .RESET_SEED(RS)) u_gal (
    .clock(clock), .reset(reset), .load(load), .seed(seed),
    .enable(enable), .Y(g_y), .wrap(g_w), .seed_err(g_e)
`ifdef LFSR_PERIOD_CNT_EN
    , .period(g_p)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [51:0] sb[$];
  logic [51:0] e;

  logic [7:0]  m_y[2];
  logic [7:0]  m_s[2];
  logic        m_w[2];
  logic        m_e[2];
  logic [31:0] m_cnt = 0;
  logic [31:0] m_per = 0;

  function automatic logic [7:0] nxt(input logic [7:0] y, input int k);
    logic [7:0] r;
    logic b;
    if (k == 0) begin
      b = 1'b0;
      for (int i = 0; i < 8; i++) if (FT[i]) b = b ^ y[i];
      r = {y[6:0], b};
    end else begin
      r = y << 1;
      if (y[7]) r = r ^ GT;
    end
    return r;
  endfunction

  function automatic logic [51:0] obs();
    return {f_y, f_w, f_e, g_y, g_w, g_e, f_p};
  endfunction

  task automatic drive(input logic r, input logic l,
                       input logic [7:0] s, input logic en);
    logic [7:0] n;
    logic [31:0] pe;
    @(negedge clock);
    reset = r; load = l; seed = s; enable = en;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_y[k] = RS; m_s[k] = RS; m_w[k] = 0; m_e[k] = 0;
      end else if (l) begin
        m_w[k] = 0;
        m_e[k] = (s == 8'h00);
        m_y[k] = (s == 8'h00) ? RS : s;
        m_s[k] = m_y[k];
      end else if (en) begin
        n = nxt(m_y[k], k);
        m_w[k] = (n == m_s[k]);
        m_e[k] = 0;
        m_y[k] = n;
      end else begin
        m_w[k] = 0; m_e[k] = 0;
      end
    end
    if (r) begin
      m_cnt = 0; m_per = 0;
    end else if (l) begin
      m_cnt = 0;
    end else if (en) begin
      if (m_w[0]) begin
        m_per = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      end
    end
`ifdef LFSR_PERIOD_CNT_EN
    pe = m_per;
`else
    pe = 32'd0;
`endif
    sb.push_back({m_y[0], m_w[0], m_e[0], m_y[1], m_w[1], m_e[1], pe});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h00, 0);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL reset_sb: got %h expected %h", obs(), e);
    end
    drive(1, 1, 8'h55, 1);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL reset_prio_sb: got %h expected %h", obs(), e);
    end
    n_cmp++;
    if ({f_y, f_w, f_e, f_p} !== {8'h01, 1'b0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_const: got Y=%h w=%b e=%b p=%0d expected Y=01 w=0 e=0 p=0",
               f_y, f_w, f_e, f_p);
    end
  endtask

  task automatic test_fib_steps();
    logic [7:0] want[3];
    want[0] = 8'hD3; want[1] = 8'hA6; want[2] = 8'h4C;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(0, 1, 8'hD3, 0);
      else drive(0, 0, 8'h00, 1);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL fib_sb[%0d]: got %h expected %h", i, obs(), e);
      end
      n_cmp++;
      if ({f_y, f_w, f_e} !== {want[i], 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL fib_const[%0d]: got Y=%h w=%b e=%b expected Y=%h w=0 e=0",
                 i, f_y, f_w, f_e, want[i]);
      end
    end
  endtask

  task automatic test_galois();
    drive(0, 1, 8'hD3, 0);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL gal_load_sb: got %h expected %h", obs(), e);
    end
    drive(0, 0, 8'h00, 1);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL gal_step_sb: got %h expected %h", obs(), e);
    end
    n_cmp++;
    if (g_y !== 8'hBB) begin
      n_bad++;
      $display("FAIL gal_const: got Y=%h expected Y=bb", g_y);
    end
  endtask

  task automatic test_wrap();
    int nw;
    nw = 0;
    drive(0, 1, 8'h01, 0);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL wrap_load_sb: got %h expected %h", obs(), e);
    end
    for (int i = 1; i <= 510; i++) begin
      drive(0, 0, 8'h00, 1);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL wrap_sb[%0d]: got %h expected %h", i, obs(), e);
      end
      if (f_w) nw++;
      if (i == 255 || i == 510) begin
        n_cmp++;
        if ({f_w, f_y} !== {1'b1, 8'h01}) begin
          n_bad++;
          $display("FAIL wrap_edge[%0d]: got w=%b Y=%h expected w=1 Y=01",
                   i, f_w, f_y);
        end
      end
    end
    n_cmp++;
    if (nw !== 2) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d expected 2", nw);
    end
`ifdef LFSR_PERIOD_CNT_EN
    n_cmp++;
    if (f_p !== 32'd255) begin
      n_bad++;
      $display("FAIL period_255: got %0d expected 255", f_p);
    end
`endif
  endtask

  task automatic test_zero_seed();
    drive(0, 1, 8'h00, 0);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL zero_sb: got %h expected %h", obs(), e);
    end
    n_cmp++;
    if ({f_y, f_e, f_w} !== {8'h01, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL zero_const: got Y=%h e=%b w=%b expected Y=01 e=1 w=0",
               f_y, f_e, f_w);
    end
    drive(0, 0, 8'h00, 0);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL zero_hold_sb: got %h expected %h", obs(), e);
    end
    n_cmp++;
    if ({f_e, f_w} !== 2'b00) begin
      n_bad++;
      $display("FAIL zero_pulse: got e=%b w=%b expected e=0 w=0", f_e, f_w);
    end
  endtask

  task automatic test_load_priority();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(0, 1, 8'hB3, 1);
      else drive(0, 0, 8'h00, 0);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL prio_sb[%0d]: got %h expected %h", i, obs(), e);
      end
      n_cmp++;
      if (f_y !== 8'hB3) begin
        n_bad++;
        $display("FAIL prio_const[%0d]: got Y=%h expected Y=b3", i, f_y);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 8'hD3, 0);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL mid_load_sb: got %h expected %h", obs(), e);
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 8'h00, 1);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL mid_step_sb[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    drive(1, 0, 8'h00, 1);
    e = sb.pop_front();
    n_cmp++;
    if ({f_y, f_p} !== {8'h01, 32'd0}) begin
      n_bad++;
      $display("FAIL mid_reset: got Y=%h p=%0d expected Y=01 p=0", f_y, f_p);
    end
    drive(0, 0, 8'h00, 1);
    e = sb.pop_front();
    n_cmp++;
    if (f_y !== 8'h02) begin
      n_bad++;
      $display("FAIL mid_after: got Y=%h expected Y=02", f_y);
    end
  endtask

  task automatic test_random();
    logic r, l, en;
    logic [7:0] s;
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      en = 1'($urandom_range(0, 1));
      drive(r, l, s, en);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL rand_sb[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fib_steps();
    test_galois();
    test_wrap();
    test_zero_seed();
    test_load_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised successor to the team's fixed 8-bit LFSR: configurable width, tap mask and Fibonacci/Galois structure.
- Adds a step enable, a seed register with all-zero lock-up protection, and a period-complete pulse.
- Sits as a pseudo-random source / test-pattern generator beside datapath blocks and benches.
- Single clock domain, synchronous reset.

Parameters:
- WIDTH, 8: state width in bits; legal range 3..32.
- TAPS, 8'hB8: tap mask, WIDTH bits wide, bit i = tap on state[i]. Default is maximal for Fibonacci with WIDTH=8. Galois needs bit0=1, e.g. 8'h1D.
- MODE, 0: 0 = Fibonacci, 1 = Galois.
- RESET_SEED, 1: state and seed value after reset; must be nonzero.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: load seed this cycle; takes priority over enable.
- seed, input, WIDTH: value captured when load=1.
- enable, input, 1: advance the LFSR one step.
- Y, output, WIDTH: current LFSR state, registered.
- wrap, output, 1: one-cycle pulse when an advance returns state to the stored seed.
- seed_err, output, 1: one-cycle pulse when load is attempted with seed==0.
- period, output, 32: last measured period; present only with LFSR_PERIOD_CNT_EN.

Behaviour:
- Reset (reset=1 at clock edge):
  - Y = RESET_SEED and seed_reg = RESET_SEED.
  - wrap = 0, seed_err = 0.
  - period = 0 and step counter = 0.
  - Reset overrides load and enable. Reset mid-sequence discards the current state.
- Priority per edge: reset > load > enable > hold.
- Load with seed != 0: Y <= seed, seed_reg <= seed, wrap <= 0, step counter <= 0.
- Load with seed == 0:
  - Y <= RESET_SEED, seed_reg <= RESET_SEED.
  - seed_err <= 1 for one cycle.
  - step counter <= 0.
- Enable (no load):
  - Fibonacci: fb = XOR-reduce(Y & TAPS); next = {Y[WIDTH-2:0], fb}.
  - Galois: m = Y[WIDTH-1]; next = {Y[WIDTH-2:0], 1'b0} XOR (m ? TAPS : 0).
  - Y <= next.
  - wrap <= 1 iff next == seed_reg, otherwise 0.
- Hold (enable=0, load=0): Y unchanged; wrap and seed_err return to 0.
- Latency: Y reflects load/enable one edge later. wrap and seed_err are registered and coincide with the Y update that caused them.
- Lock-up: the all-zero state is unreachable by construction (zero seed is rejected, RESET_SEED is nonzero), so no runtime zero detect is required.
- Wrap-around: a maximal TAPS gives period 2^WIDTH-1; wrap pulses once per period. A non-maximal TAPS simply gives a shorter period.
- Y is free of combinational paths from inputs.

Optional Feature:
- Macro: LFSR_PERIOD_CNT_EN.
- Defined:
  - A 32-bit step counter increments on each enabled advance and clears on load/reset.
  - When wrap is generated, period <= counter+1 and counter <= 0.
  - The counter saturates at 32'hFFFF_FFFF without wrapping.
- Undefined: no counter logic and no period port. All other behaviour is identical.

Test Plan:
- Reset, then load=1 with seed=8'hD3; next edge enable=1, two edges (MODE=0, TAPS=8'hB8) -> Y = D3, A6, 4C; wrap=0, seed_err=0.
- MODE=1, TAPS=8'h1D, load 8'hD3, one enable -> Y=8'hBB.
- Load 8'h01, enable held for 255 edges (MODE=0, B8) -> wrap pulses exactly on edge 255 with Y=8'h01, and again on edge 510. With LFSR_PERIOD_CNT_EN, period=255.
- load=1, seed=8'h00 -> Y=RESET_SEED (8'h01), seed_err=1 for exactly one cycle, no wrap.
- load=1 and enable=1 on the same edge with seed=8'hB3 -> Y=8'hB3, no advance. enable=0 for 5 cycles -> Y holds 8'hB3.
- Reset asserted mid-sequence, 20 steps after load of D3 -> next edge Y=8'h01; period unchanged? No: period=0 with LFSR_PERIOD_CNT_EN. The following enable gives Y=8'h02.
